// File: rtl/cp0_regs.sv
// cp0_regs -- MIPS coprocessor-0 register file.
//
// Holds BadVAddr, Count, Compare, Status, Cause, EPC, PRId, EBase and Config.
// Commits the MEM-stage exception decision (EXL, EPC, Cause.BD/ExcCode,
// BadVAddr), serves MFC0 reads combinationally and MTC0 writes on the clock
// edge, and exposes Status/Cause/EPC/EBase to the exception logic.
//
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   we/waddr/wsel/wdata    MTC0 write port
//   raddr/rsel/rdata       MFC0 read port (rdata combinational)
//   except_type            committed exception code (EXC_CODE_* encoding)
//   pcM, badvaddrM         PC and faulting address of the excepting instruction
//   is_in_delayslotM       excepting instruction sits in a branch delay slot
//   hw_int                 external interrupt levels, already synchronous
//   status_o/cause_o/epc_o/ebase_o  current register values
//   timer_int_o            Cause.TI
//
// Build option: define CP0_TIMER_INT_EN to enable the Count/Compare timer
// interrupt. Without it TI is tied to 0 and IP7 follows hw_int[5] alone.
module cp0_regs (
  input  logic        clk,
  input  logic        resetn,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [2:0]  wsel,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  input  logic [2:0]  rsel,
  output logic [31:0] rdata,
  input  logic [4:0]  except_type,
  input  logic [31:0] pcM,
  input  logic [31:0] badvaddrM,
  input  logic        is_in_delayslotM,
  input  logic [5:0]  hw_int,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] ebase_o,
  output logic        timer_int_o
);

  // Exception codes (EXC_CODE_* encoding shared with the pipeline).
  localparam logic [4:0] EXC_CODE_MOD   = 5'h01;
  localparam logic [4:0] EXC_CODE_TLBL  = 5'h02;
  localparam logic [4:0] EXC_CODE_TLBS  = 5'h03;
  localparam logic [4:0] EXC_CODE_ADEL  = 5'h04;
  localparam logic [4:0] EXC_CODE_ADES  = 5'h05;
  localparam logic [4:0] EXC_CODE_ERET  = 5'h1e;
  localparam logic [4:0] EXC_CODE_NOEXC = 5'h1f;

  localparam logic [31:0] PRID_VALUE   = 32'h0000_4220;
  localparam logic [31:0] CONFIG_VALUE = 32'h8000_0000;

  // Architectural state, kept as the writable/hardware fields only.
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] epc_q, epc_d;
  logic        bev_q, bev_d;
  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic        ti_q, ti_d;
  logic [5:0]  ip_hw_q, ip_hw_d;     // Cause.IP[15:10]
  logic [1:0]  ip_sw_q, ip_sw_d;     // Cause.IP[9:8]
  logic [4:0]  exccode_q, exccode_d;
  logic [17:0] ebase_q, ebase_d;     // EBase[29:12]
  logic        tick_q, tick_d;       // Count advances when this is 1
  logic [31:0] count_inc;

  logic exc_commit, eret_commit, mtc0;
  logic wr_count, wr_compare, wr_status, wr_cause, wr_epc, wr_ebase;
  logic addr_exc;

  assign exc_commit  = (except_type != EXC_CODE_NOEXC) && (except_type != EXC_CODE_ERET);
  assign eret_commit = (except_type == EXC_CODE_ERET);
  // A committing exception or ERET squashes the MTC0 in the same cycle.
  assign mtc0        = we && !exc_commit && !eret_commit;

  assign wr_count   = mtc0 && (waddr == 5'd9)  && (wsel == 3'd0);
  assign wr_compare = mtc0 && (waddr == 5'd11) && (wsel == 3'd0);
  assign wr_status  = mtc0 && (waddr == 5'd12) && (wsel == 3'd0);
  assign wr_cause   = mtc0 && (waddr == 5'd13) && (wsel == 3'd0);
  assign wr_epc     = mtc0 && (waddr == 5'd14) && (wsel == 3'd0);
  assign wr_ebase   = mtc0 && (waddr == 5'd15) && (wsel == 3'd1);

  assign addr_exc = (except_type == EXC_CODE_ADEL) || (except_type == EXC_CODE_ADES) ||
                    (except_type == EXC_CODE_TLBL) || (except_type == EXC_CODE_TLBS) ||
                    (except_type == EXC_CODE_MOD);

  always_comb begin
    // NOTE: every next-state signal is given its hold value first, so no
    // branch can leave one unassigned and infer a latch.
    badvaddr_d = badvaddr_q;
    count_d    = count_q;
    compare_d  = compare_q;
    epc_d      = epc_q;
    bev_d      = bev_q;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ti_d       = ti_q;
    ip_sw_d    = ip_sw_q;
    exccode_d  = exccode_q;
    ebase_d    = ebase_q;
    tick_d     = ~tick_q;
    count_inc  = count_q + 32'd1;

    // Count: a software write beats the tick increment.
    if (wr_count) begin
      count_d = wdata;
    end else if (tick_q) begin
      count_d = count_inc;
    end
    if (wr_compare) begin
      compare_d = wdata;
    end

`ifdef CP0_TIMER_INT_EN
    // Writing Compare acknowledges the timer; it beats a same-cycle match.
    if (wr_compare) begin
      ti_d = 1'b0;
    end else if (!wr_count && tick_q && (count_inc == compare_q)) begin
      ti_d = 1'b1;
    end
`else
    ti_d = 1'b0;
`endif

    // IP7 carries the timer, so it sees the TI value being committed now.
    ip_hw_d = {hw_int[5] | ti_d, hw_int[4:0]};

    // Software-writable fields only; hardware-owned fields are untouched.
    if (wr_status) begin
      bev_d = wdata[22];
      im_d  = wdata[15:8];
      exl_d = wdata[1];
      ie_d  = wdata[0];
    end
    if (wr_cause) begin
      ip_sw_d = wdata[9:8];
    end
    if (wr_epc) begin
      epc_d = wdata;
    end
    if (wr_ebase) begin
      ebase_d = wdata[29:12];
    end

    if (exc_commit) begin
      exccode_d = except_type;
      exl_d     = 1'b1;
      // A nested exception keeps the original return address and BD.
      if (!exl_q) begin
        epc_d = is_in_delayslotM ? (pcM - 32'd4) : pcM;
        bd_d  = is_in_delayslotM;
      end
      if (addr_exc) begin
        badvaddr_d = badvaddrM;
      end
    end else if (eret_commit) begin
      exl_d = 1'b0;
    end
  end

  // NOTE: resetn is sampled only on the rising edge (synchronous reset), and
  // all state uses non-blocking assignments so every register sees the
  // pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      badvaddr_q <= 32'd0;
      count_q    <= 32'd0;
      compare_q  <= 32'd0;
      epc_q      <= 32'd0;
      bev_q      <= 1'b1;
      im_q       <= 8'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      ip_hw_q    <= 6'd0;
      ip_sw_q    <= 2'd0;
      exccode_q  <= 5'd0;
      ebase_q    <= 18'd0;
      tick_q     <= 1'b0;
    end else begin
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      epc_q      <= epc_d;
      bev_q      <= bev_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ti_q       <= ti_d;
      ip_hw_q    <= ip_hw_d;
      ip_sw_q    <= ip_sw_d;
      exccode_q  <= exccode_d;
      ebase_q    <= ebase_d;
      tick_q     <= tick_d;
    end
  end

  assign status_o    = {9'd0, bev_q, 6'd0, im_q, 6'd0, exl_q, ie_q};
  assign cause_o     = {bd_q, ti_q, 14'd0, ip_hw_q, ip_sw_q, 1'b0, exccode_q, 2'b00};
  assign epc_o       = epc_q;
  assign ebase_o     = {2'b10, ebase_q, 12'd0};
  assign timer_int_o = ti_q;

  // MFC0: combinational from the current registers, no write bypass.
  always_comb begin
    rdata = 32'd0;
    case ({raddr, rsel})
      {5'd8,  3'd0}: rdata = badvaddr_q;
      {5'd9,  3'd0}: rdata = count_q;
      {5'd11, 3'd0}: rdata = compare_q;
      {5'd12, 3'd0}: rdata = status_o;
      {5'd13, 3'd0}: rdata = cause_o;
      {5'd14, 3'd0}: rdata = epc_q;
      {5'd15, 3'd0}: rdata = PRID_VALUE;
      {5'd15, 3'd1}: rdata = ebase_o;
      {5'd16, 3'd0}: rdata = CONFIG_VALUE;
      default:       rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_regs.sv
// tb_cp0_regs -- scoreboard bench for cp0_regs.
// The driver applies one stimulus per cycle, pushes the outputs the reference
// model says the DUT shows during that cycle, then advances the model across
// the clock edge. The monitor pops and compares on every falling edge.
module tb_cp0_regs;

  localparam logic [4:0] EXC_INT   = 5'h00;
  localparam logic [4:0] EXC_MOD   = 5'h01;
  localparam logic [4:0] EXC_TLBL  = 5'h02;
  localparam logic [4:0] EXC_TLBS  = 5'h03;
  localparam logic [4:0] EXC_ADEL  = 5'h04;
  localparam logic [4:0] EXC_ADES  = 5'h05;
  localparam logic [4:0] EXC_SYS   = 5'h08;
  localparam logic [4:0] EXC_BP    = 5'h09;
  localparam logic [4:0] EXC_RI    = 5'h0a;
  localparam logic [4:0] EXC_OV    = 5'h0c;
  localparam logic [4:0] EXC_ERET  = 5'h1e;
  localparam logic [4:0] EXC_NOEXC = 5'h1f;

`ifdef CP0_TIMER_INT_EN
  localparam bit TIMER_ON = 1'b1;
`else
  localparam bit TIMER_ON = 1'b0;
`endif

  typedef struct {
    logic        resetn;
    logic        we;
    logic [4:0]  waddr;
    logic [2:0]  wsel;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [2:0]  rsel;
    logic [4:0]  exc;
    logic [31:0] pc;
    logic [31:0] badv;
    logic        ds;
    logic [5:0]  hw;
  } stim_t;

  typedef struct {
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] ebase;
    logic [31:0] rd;
    logic        ti;
    logic [4:0]  raddr;
    logic [2:0]  rsel;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        we;
  logic [4:0]  waddr;
  logic [2:0]  wsel;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [2:0]  rsel;
  logic [31:0] rdata;
  logic [4:0]  except_type;
  logic [31:0] pcM;
  logic [31:0] badvaddrM;
  logic        is_in_delayslotM;
  logic [5:0]  hw_int;
  logic [31:0] status_o, cause_o, epc_o, ebase_o;
  logic        timer_int_o;

  cp0_regs dut (
    .clk(clk), .resetn(resetn),
    .we(we), .waddr(waddr), .wsel(wsel), .wdata(wdata),
    .raddr(raddr), .rsel(rsel), .rdata(rdata),
    .except_type(except_type), .pcM(pcM), .badvaddrM(badvaddrM),
    .is_in_delayslotM(is_in_delayslotM), .hw_int(hw_int),
    .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o), .ebase_o(ebase_o),
    .timer_int_o(timer_int_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t sb[$];

  // Reference model: whole architectural registers as 32-bit words.
  logic [31:0] m_status, m_cause, m_epc, m_badv, m_count, m_compare, m_ebase;
  int          m_edges;
  bit          m_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a, input logic [2:0] s);
    logic [31:0] r;
    r = 32'd0;
    if (s == 3'd0) begin
      case (a)
        5'd8:    r = m_badv;
        5'd9:    r = m_count;
        5'd11:   r = m_compare;
        5'd12:   r = m_status;
        5'd13:   r = m_cause;
        5'd14:   r = m_epc;
        5'd15:   r = 32'h0000_4220;
        5'd16:   r = 32'h8000_0000;
        default: r = 32'd0;
      endcase
    end else if (a == 5'd15 && s == 3'd1) begin
      r = m_ebase;
    end
    return r;
  endfunction

  task automatic model_edge(input stim_t s);
    logic exc, eret, mtc, ti;
    if (!s.resetn) begin
      m_status = 32'h0040_0000; m_cause = 32'd0; m_epc = 32'd0; m_badv = 32'd0;
      m_count = 32'd0; m_compare = 32'd0; m_ebase = 32'h8000_0000;
      m_edges = 0; m_valid = 1'b1;
      return;
    end
    exc  = (s.exc != EXC_NOEXC) && (s.exc != EXC_ERET);
    eret = (s.exc == EXC_ERET);
    mtc  = s.we && !exc && !eret;
    ti   = m_cause[30];
    m_edges++;
    // Count moves on every second edge after reset.
    if (mtc && s.waddr == 5'd9 && s.wsel == 3'd0) begin
      m_count = s.wdata;
    end else if (m_edges % 2 == 0) begin
      m_count = m_count + 32'd1;
      if (m_count == m_compare) ti = 1'b1;
    end
    if (mtc && s.waddr == 5'd11 && s.wsel == 3'd0) begin
      m_compare = s.wdata;
      ti = 1'b0;
    end
    if (!TIMER_ON) ti = 1'b0;
    if (mtc && s.waddr == 5'd12 && s.wsel == 3'd0)
      m_status = (m_status & ~32'h0040_FF03) | (s.wdata & 32'h0040_FF03);
    if (mtc && s.waddr == 5'd13 && s.wsel == 3'd0)
      m_cause = (m_cause & ~32'h0000_0300) | (s.wdata & 32'h0000_0300);
    if (mtc && s.waddr == 5'd14 && s.wsel == 3'd0)
      m_epc = s.wdata;
    if (mtc && s.waddr == 5'd15 && s.wsel == 3'd1)
      m_ebase = (m_ebase & ~32'h3FFF_F000) | (s.wdata & 32'h3FFF_F000);
    if (exc) begin
      m_cause[6:2] = s.exc;
      if (!m_status[1]) begin
        m_epc = s.ds ? s.pc - 32'd4 : s.pc;
        m_cause[31] = s.ds;
      end
      m_status[1] = 1'b1;
      if (s.exc inside {EXC_ADEL, EXC_ADES, EXC_TLBL, EXC_TLBS, EXC_MOD})
        m_badv = s.badv;
    end
    if (eret) m_status[1] = 1'b0;
    m_cause[30]    = ti;
    m_cause[15:10] = {s.hw[5] | ti, s.hw[4:0]};
  endtask

  // Called at posedge+1; returns at posedge+1 after the edge that used s.
  task automatic drive(input stim_t s);
    exp_t e;
    resetn = s.resetn; we = s.we; waddr = s.waddr; wsel = s.wsel; wdata = s.wdata;
    raddr = s.raddr; rsel = s.rsel; except_type = s.exc; pcM = s.pc;
    badvaddrM = s.badv; is_in_delayslotM = s.ds; hw_int = s.hw;
    if (m_valid) begin
      e.status = m_status; e.cause = m_cause; e.epc = m_epc; e.ebase = m_ebase;
      e.ti = m_cause[30]; e.raddr = s.raddr; e.rsel = s.rsel;
      e.rd = m_read(s.raddr, s.rsel);
      sb.push_back(e);
    end
    model_edge(s);
    @(posedge clk);
    #1;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.resetn = 1'b1; s.we = 1'b0; s.waddr = 5'd0; s.wsel = 3'd0; s.wdata = 32'd0;
    s.raddr = 5'd9; s.rsel = 3'd0; s.exc = EXC_NOEXC; s.pc = 32'd0; s.badv = 32'd0;
    s.ds = 1'b0; s.hw = 6'd0;
    return s;
  endfunction

  function automatic stim_t mtc0(input logic [4:0] a, input logic [2:0] sel, input logic [31:0] d);
    stim_t s;
    s = idle(); s.we = 1'b1; s.waddr = a; s.wsel = sel; s.wdata = d;
    return s;
  endfunction

  function automatic stim_t excp(input logic [4:0] code, input logic [31:0] pc,
                                 input logic [31:0] badv, input logic ds);
    stim_t s;
    s = idle(); s.exc = code; s.pc = pc; s.badv = badv; s.ds = ds;
    return s;
  endfunction

  function automatic logic [4:0] pick_addr();
    case ($urandom_range(0, 8))
      0: return 5'd8;
      1: return 5'd9;
      2: return 5'd11;
      3: return 5'd12;
      4: return 5'd13;
      5: return 5'd14;
      6: return 5'd15;
      7: return 5'd16;
      default: return 5'($urandom);
    endcase
  endfunction

  function automatic logic [2:0] pick_sel();
    int r;
    r = $urandom_range(0, 19);
    if (r < 5) return 3'd1;
    if (r == 5) return 3'($urandom);
    return 3'd0;
  endfunction

  function automatic logic [4:0] pick_exc();
    case ($urandom_range(0, 11))
      0: return EXC_INT;
      1: return EXC_MOD;
      2: return EXC_TLBL;
      3: return EXC_TLBS;
      4: return EXC_ADEL;
      5: return EXC_ADES;
      6: return EXC_SYS;
      7: return EXC_BP;
      8: return EXC_RI;
      9: return EXC_OV;
      default: return EXC_ERET;
    endcase
  endfunction

  // Monitor: one scoreboard entry per cycle, compared away from the rising edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("status_o", status_o, e.status);
        check("cause_o", cause_o, e.cause);
        check("epc_o", epc_o, e.epc);
        check("ebase_o", ebase_o, e.ebase);
        check("timer_int_o", 32'(timer_int_o), 32'(e.ti));
        check($sformatf("rdata[%0d/%0d]", e.raddr, e.rsel), rdata, e.rd);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    stim_t s;
    bit    seen;

    // Reset held for two cycles.
    s = idle(); s.resetn = 1'b0;
    drive(s);
    drive(s);
    check("rst_status", status_o, 32'h0040_0000);
    check("rst_ebase", ebase_o, 32'h8000_0000);
    check("rst_cause", cause_o, 32'd0);
    check("rst_epc", epc_o, 32'd0);
    check("rst_ti", 32'(timer_int_o), 32'd0);
    check("rst_count", rdata, 32'd0);
    drive(idle());

    // Timer: Compare=5, Count=0, then wait for TI (bounded).
    drive(mtc0(5'd11, 3'd0, 32'd5));
    drive(mtc0(5'd9, 3'd0, 32'd0));
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      drive(idle());
      seen = timer_int_o;
    end
    check("timer_set", 32'(timer_int_o), 32'(TIMER_ON));
    check("timer_ip7", 32'(cause_o[15]), 32'(TIMER_ON));
    drive(mtc0(5'd11, 3'd0, 32'd100));
    check("timer_clear", 32'(timer_int_o), 32'd0);

    // Delay-slot exception, then a nested one.
    drive(excp(EXC_OV, 32'hBFC0_0104, 32'd0, 1'b1));
    check("ds_epc", epc_o, 32'hBFC0_0100);
    check("ds_bd", 32'(cause_o[31]), 32'd1);
    check("ds_exccode", 32'(cause_o[6:2]), 32'(EXC_OV));
    check("ds_exl", 32'(status_o[1]), 32'd1);
    drive(excp(EXC_SYS, 32'h0000_0500, 32'h1111_1111, 1'b0));
    check("nested_epc", epc_o, 32'hBFC0_0100);
    check("nested_exccode", 32'(cause_o[6:2]), 32'(EXC_SYS));
    drive(excp(EXC_ERET, 32'd0, 32'd0, 1'b0));
    check("eret_exl", 32'(status_o[1]), 32'd0);

    // Address error captures BadVAddr; SYS does not.
    drive(excp(EXC_ADEL, 32'h0000_1000, 32'h8000_0003, 1'b0));
    raddr = 5'd8; rsel = 3'd0; #1;
    check("adel_badv", rdata, 32'h8000_0003);
    drive(excp(EXC_SYS, 32'h0000_2000, 32'hDEAD_BEEF, 1'b0));
    raddr = 5'd8; rsel = 3'd0; #1;
    check("sys_badv", rdata, 32'h8000_0003);
    drive(excp(EXC_ERET, 32'd0, 32'd0, 1'b0));

    // Exception and MTC0 EPC in the same cycle: MTC0 is dropped.
    s = excp(EXC_SYS, 32'h0000_0040, 32'd0, 1'b0);
    s.we = 1'b1; s.waddr = 5'd14; s.wdata = 32'h0000_1234;
    drive(s);
    check("conflict_epc", epc_o, 32'h0000_0040);
    drive(excp(EXC_ERET, 32'd0, 32'd0, 1'b0));
    check("conflict_eret_exl", 32'(status_o[1]), 32'd0);

    // Count wrap, observed through the scoreboard reads.
    drive(mtc0(5'd9, 3'd0, 32'hFFFF_FFFF));
    for (int i = 0; i < 4; i++) drive(idle());

    // Masked writes from a clean reset.
    s = idle(); s.resetn = 1'b0;
    drive(s);
    drive(mtc0(5'd13, 3'd0, 32'hFFFF_FFFF));
    check("mask_cause", cause_o, 32'h0000_0300);
    drive(mtc0(5'd12, 3'd0, 32'hFFFF_FFFF));
    check("mask_status", status_o, 32'h0040_FF03);
    drive(mtc0(5'd15, 3'd1, 32'hFFFF_FFFF));
    check("mask_ebase", ebase_o, 32'hBFFF_F000);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      s = idle();
      s.resetn = ($urandom_range(0, 299) != 0);
      s.we     = ($urandom_range(0, 9) < 3);
      s.waddr  = pick_addr();
      s.wsel   = pick_sel();
      // Small values keep Compare within reach of Count so matches happen.
      s.wdata  = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 60));
      s.raddr  = pick_addr();
      s.rsel   = pick_sel();
      s.exc    = ($urandom_range(0, 9) < 2) ? pick_exc() : EXC_NOEXC;
      s.pc     = $urandom & 32'hFFFF_FFFC;
      s.badv   = $urandom;
      s.ds     = 1'($urandom_range(0, 1));
      s.hw     = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      drive(s);
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    check("scoreboard_drain", 32'(sb.size()), 32'd0);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
